// File: rtl/exce_ctrl_if.sv
// Handshake between main control and the exception sequencer: request/cause flags in,
// exception-entry strobes and status out.
interface exce_ctrl_if;
  logic       exc_req;
  logic       opcode_invalid;
  logic       overflow;
  logic       div_zero;
  logic       busy;
  logic [1:0] exce_sel;
  logic       iord_exc;
  logic       mem_rd;
  logic       epc_write;
  logic       mdr_write;
  logic       pc_load;
  logic       pc_src_exc;
  logic       done;
  logic [1:0] cause;
  logic       exc_lost;

  modport master (
    output exc_req, opcode_invalid, overflow, div_zero,
    input  busy, exce_sel, iord_exc, mem_rd, epc_write, mdr_write,
           pc_load, pc_src_exc, done, cause, exc_lost
  );

  modport slave (
    input  exc_req, opcode_invalid, overflow, div_zero,
    output busy, exce_sel, iord_exc, mem_rd, epc_write, mdr_write,
           pc_load, pc_src_exc, done, cause, exc_lost
  );
endinterface

// File: rtl/exce_ctrl_unit.sv
// Exception-entry sequencer: saves EPC, fetches the handler byte at 253/254/255
// and loads it into PC. All outputs are registered alongside the state.
module exce_ctrl_unit #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  exce_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam logic [1:0]  SEL_IDLE = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SAVE_EPC,
    MEM_RD,
    LATCH,
    LOAD_PC
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       req_cause;
  logic             any_flag;

  // Fixed priority: opcode_invalid > overflow > div_zero
  always_comb begin
    any_flag = bus.opcode_invalid | bus.overflow | bus.div_zero;
    if (bus.opcode_invalid)  req_cause = 2'b00;
    else if (bus.overflow)   req_cause = 2'b01;
    else                     req_cause = 2'b10;
  end

  // Outputs are set for the state being entered, so they behave as Moore outputs of state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.cause      <= 2'b00;
      bus.exc_lost   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.exce_sel   <= SEL_IDLE;
      bus.iord_exc   <= 1'b0;
      bus.mem_rd     <= 1'b0;
      bus.epc_write  <= 1'b0;
      bus.mdr_write  <= 1'b0;
      bus.pc_load    <= 1'b0;
      bus.pc_src_exc <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      bus.iord_exc   <= 1'b0;
      bus.mem_rd     <= 1'b0;
      bus.epc_write  <= 1'b0;
      bus.mdr_write  <= 1'b0;
      bus.pc_load    <= 1'b0;
      bus.pc_src_exc <= 1'b0;
      bus.done       <= 1'b0;

      if (state != IDLE && bus.exc_req) bus.exc_lost <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.exc_req && any_flag) begin
            state         <= SAVE_EPC;
            bus.cause     <= req_cause;
            bus.exce_sel  <= req_cause;
            bus.busy      <= 1'b1;
            bus.epc_write <= 1'b1;
          end
        end
        SAVE_EPC: begin
          state        <= MEM_RD;
          cnt          <= CNT_W'(MEM_WAIT - 1);
          bus.mem_rd   <= 1'b1;
          bus.iord_exc <= 1'b1;
        end
        MEM_RD: begin
          if (cnt == '0) begin
            state         <= LATCH;
            bus.mdr_write <= 1'b1;
          end else begin
            cnt          <= cnt - CNT_W'(1);
            bus.mem_rd   <= 1'b1;
            bus.iord_exc <= 1'b1;
          end
        end
        LATCH: begin
          state          <= LOAD_PC;
          bus.pc_load    <= 1'b1;
          bus.pc_src_exc <= 1'b1;
          bus.done       <= 1'b1;
        end
        LOAD_PC: begin
          state        <= IDLE;
          bus.busy     <= 1'b0;
          bus.exce_sel <= SEL_IDLE;
        end
        default: begin
          state        <= IDLE;
          bus.busy     <= 1'b0;
          bus.exce_sel <= SEL_IDLE;
        end
      endcase
    end
  end

endmodule
